// File: rtl/multi_level_priority_arbiter_if.sv
// Request/grant bundle between requesters, the multi-level priority arbiter and its consumer.
// The slave modport is the arbiter's view; the master modport is the requester/consumer view.
interface multi_level_priority_arbiter_if #(
  parameter int NUM_REQUEST                  = 3,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int PRIORITY_WIDTH               = 2
);
  localparam int SRC_W = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1;

  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_in;
  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in;
  logic [NUM_REQUEST*PRIORITY_WIDTH-1:0]               request_priority_flatted_in;
  logic [NUM_REQUEST-1:0]                              issue_ack_out;
  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out;
  logic                                                request_valid_out;
  logic [SRC_W-1:0]                                    request_source_out;
  logic                                                issue_ack_in;

  modport slave (
    input  request_flatted_in, request_valid_flatted_in, request_priority_flatted_in, issue_ack_in,
    output issue_ack_out, request_out, request_valid_out, request_source_out
  );

  modport master (
    output request_flatted_in, request_valid_flatted_in, request_priority_flatted_in, issue_ack_in,
    input  issue_ack_out, request_out, request_valid_out, request_source_out
  );
endinterface

// File: rtl/multi_level_priority_arbiter.sv
// N-to-1 arbiter: highest effective level wins, round-robin per level, registered grant held until ack.
// Define MULTI_LEVEL_PRIORITY_ARBITER_AGING_EN to promote requesters that keep losing arbitration.
module multi_level_priority_arbiter #(
  parameter int NUM_REQUEST                  = 3,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int NUM_PRIORITY_LEVELS          = 4,
  parameter int PRIORITY_WIDTH               = 2,
  parameter int AGE_THRESHOLD                = 8
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  multi_level_priority_arbiter_if.slave arb_bus
);
  localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int SRC_W = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1;

  typedef logic [PRIORITY_WIDTH-1:0] lvl_t;
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                 r_state, w_state_next;
  logic [SRC_W-1:0]       r_rr_ptr [NUM_PRIORITY_LEVELS];
  logic                   r_valid_out;
  logic [W-1:0]           r_request_out;
  logic [SRC_W-1:0]       r_source_out;
  logic [NUM_REQUEST-1:0] r_issue_ack;

  lvl_t                   w_eff [NUM_REQUEST];
  lvl_t                   w_max_lvl;
  logic                   w_any;
  logic [NUM_REQUEST-1:0] w_cand;
  logic [SRC_W-1:0]       w_ptr, w_win, w_win_next;
  logic [W-1:0]           w_win_data;
  logic                   w_found;
  logic                   w_grant;

`ifdef MULTI_LEVEL_PRIORITY_ARBITER_AGING_EN
  localparam int AGE_W = $clog2(AGE_THRESHOLD + 1);
  logic [AGE_W-1:0] r_age [NUM_REQUEST];
`endif

  function automatic lvl_t clamp_level(input lvl_t p);
    if (int'(p) >= NUM_PRIORITY_LEVELS) return lvl_t'(NUM_PRIORITY_LEVELS - 1);
    return p;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQUEST; i++) begin
      w_eff[i] = clamp_level(arb_bus.request_priority_flatted_in[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]);
`ifdef MULTI_LEVEL_PRIORITY_ARBITER_AGING_EN
      if (r_age[i] == AGE_W'(AGE_THRESHOLD)) w_eff[i] = lvl_t'(NUM_PRIORITY_LEVELS - 1);
`endif
    end
  end

  always_comb begin
    w_max_lvl = '0;
    w_any     = 1'b0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      if (arb_bus.request_valid_flatted_in[i]) begin
        w_any = 1'b1;
        if (w_eff[i] > w_max_lvl) w_max_lvl = w_eff[i];
      end
    end
    for (int i = 0; i < NUM_REQUEST; i++)
      w_cand[i] = arb_bus.request_valid_flatted_in[i] && (w_eff[i] == w_max_lvl);

    w_ptr = '0;
    for (int l = 0; l < NUM_PRIORITY_LEVELS; l++)
      if (lvl_t'(l) == w_max_lvl) w_ptr = r_rr_ptr[l];

    // Rotating scan starting at the winning level's pointer; k is the distance from the pointer.
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQUEST; k++) begin
      for (int j = 0; j < NUM_REQUEST; j++) begin
        if (!w_found && w_cand[j] &&
            ((int'(w_ptr) + k == j) || (int'(w_ptr) + k - NUM_REQUEST == j))) begin
          w_found = 1'b1;
          w_win   = SRC_W'(j);
        end
      end
    end

    w_win_next = (int'(w_win) == NUM_REQUEST - 1) ? '0 : w_win + SRC_W'(1);
    w_win_data = '0;
    for (int j = 0; j < NUM_REQUEST; j++)
      if (SRC_W'(j) == w_win) w_win_data = arb_bus.request_flatted_in[j*W +: W];

    w_grant = (r_state == S_IDLE) && w_any;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_HOLD;
      S_HOLD:  if (arb_bus.issue_ack_in) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_valid_out   <= 1'b0;
      r_request_out <= '0;
      r_source_out  <= '0;
      r_issue_ack   <= '0;
      for (int l = 0; l < NUM_PRIORITY_LEVELS; l++) r_rr_ptr[l] <= '0;
    end else begin
      r_issue_ack <= '0;
      if (w_grant) begin
        r_request_out <= w_win_data;
        r_source_out  <= w_win;
        r_valid_out   <= 1'b1;
        r_issue_ack   <= NUM_REQUEST'(1) << w_win;
        for (int l = 0; l < NUM_PRIORITY_LEVELS; l++)
          if (lvl_t'(l) == w_max_lvl) r_rr_ptr[l] <= w_win_next;
      end else if (r_state == S_HOLD && arb_bus.issue_ack_in) begin
        r_valid_out <= 1'b0;
      end
    end
  end

`ifdef MULTI_LEVEL_PRIORITY_ARBITER_AGING_EN
  // Age only advances on grant edges; idle requesters and the winner restart from zero.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REQUEST; i++) r_age[i] <= '0;
    end else if (w_grant) begin
      for (int i = 0; i < NUM_REQUEST; i++) begin
        if (!arb_bus.request_valid_flatted_in[i] || SRC_W'(i) == w_win) r_age[i] <= '0;
        else if (r_age[i] != AGE_W'(AGE_THRESHOLD)) r_age[i] <= r_age[i] + AGE_W'(1);
      end
    end
  end
`endif

  assign arb_bus.issue_ack_out      = r_issue_ack;
  assign arb_bus.request_out        = r_request_out;
  assign arb_bus.request_valid_out  = r_valid_out;
  assign arb_bus.request_source_out = r_source_out;
endmodule
